datamem_responder: RTL
======================

Name: datamem_responder

Overview:
- Data-memory responder: the far end of the memread/memwrite/memtoreg control path.
- Accepts one word load or store per request from the datapath.
- Inserts a fixed number of wait states, then returns a one-cycle ready pulse with read data or write completion.
- Sits between the datapath MEM stage and an internal word-organised storage array.
- Flags malformed requests (misaligned address, simultaneous read and write) without touching storage.

Parameters:
- ADDR_WIDTH, 10: byte-address width. Storage depth is 2^(ADDR_WIDTH-2) 32-bit words.
- WAIT_CYCLES, 2: wait states between request acceptance and response. Legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- memread  input  1  load request; sampled only in IDLE.
- memwrite  input  1  store request; sampled only in IDLE.
- addr  input  ADDR_WIDTH  byte address; addr[1:0] must be 00.
- wdata  input  32  store data; sampled with the request.
- rdata  output  32  load data; valid only while ready=1 and err=0.
- ready  output  1  one-cycle response pulse, for both completion and error.
- busy  output  1  high from acceptance through the response cycle.
- err  output  1  high together with ready for a rejected request.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; rdata=0; ready=0; busy=0; err=0; wait counter=0. Storage contents are not reset.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP, ERR.
- IDLE transitions:
  - memread^memwrite with addr[1:0]==00: latch addr, wdata and op. Go to WAIT with counter=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES==0.
  - memread&memwrite, or any request with addr[1:0]!=00: go to ERR. Storage is untouched.
  - No request: stay in IDLE.
- WAIT: counter decrements each cycle. When counter==1, go to RESP. Input changes are ignored.
- RESP (exactly one cycle): ready=1, err=0.
  - Read: rdata = mem[latched addr[ADDR_WIDTH-1:2]].
  - Write: mem[latched addr] <= latched wdata on the clock edge entering RESP; rdata holds its previous value.
  - Next state is IDLE.
- ERR (one cycle): ready=1, err=1, rdata=0. Next state is IDLE.
- busy=1 in WAIT, RESP and ERR; busy=0 in IDLE.
- Latency: a request sampled at edge N produces ready high during cycle N+1+WAIT_CYCLES. An error response is high during cycle N+1.
- Back-to-back: the earliest next acceptance is the edge after the RESP/ERR cycle, i.e. at least one IDLE cycle between responses. A request held high across that IDLE cycle is accepted there.
- Requests asserted while busy=1 are ignored and are not queued.
- Read-after-write to the same address returns the new data; the write commits before the next read can be accepted.
- Reset mid-operation: return to IDLE immediately and clear outputs. A pending write not yet committed is discarded. A write already committed stays committed.
- Address wrap: none. addr covers the full array exactly.

Test Plan:
- WAIT_CYCLES=2, reset then idle → ready=0, busy=0, err=0, rdata=0 for 5 cycles.
- Store addr=0x010, wdata=0xDEADBEEF at edge N → busy high N+1..N+3; ready=1, err=0 only in cycle N+3. Then load addr=0x010 → ready in its third cycle with rdata=0xDEADBEEF.
- Store 0x11111111 to 0x004 and 0x22222222 to 0x3FC (last word), then load both → rdata 0x11111111 and 0x22222222; no aliasing.
- Load addr=0x006 (misaligned), and separately memread=memwrite=1 at addr=0x008 → one cycle later ready=1, err=1, rdata=0. A later load of 0x008 returns its prior contents unchanged.
- Hold memread=1 with addr=0x004 continuously → responses every WAIT_CYCLES+2 = 4 cycles. Toggling addr during WAIT does not alter the returned data.
- Store to 0x020 with rst pulsed during WAIT → outputs 0 immediately; a subsequent load of 0x020 returns the pre-store value.

Source files
------------

// File: rtl/datamem_responder.sv
// datamem_responder: word load/store responder with fixed wait states and error flagging
module datamem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t                  state, nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_wdata;
    logic                    lat_wr;
    logic                    req_ok, req_bad;
    logic [ADDR_WIDTH-3:0]   idx;
    logic [31:0]             wd;
    logic                    wr;
    logic [31:0]             mem [DEPTH];

    // next state, plus the access source: live inputs when RESP is entered straight from IDLE
    always_comb begin
        req_ok  = (memread ^ memwrite) && (addr[1:0] == 2'b00);
        req_bad = (memread | memwrite) && !req_ok;
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    nxt     = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt_nxt = 4'(WAIT_CYCLES);
                end else if (req_bad) begin
                    nxt = ERR;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                nxt     = (cnt == 4'd1) ? RESP : WAIT;
            end
            default: nxt = IDLE;
        endcase
        idx = (state == IDLE) ? addr[ADDR_WIDTH-1:2] : lat_addr[ADDR_WIDTH-1:2];
        wd  = (state == IDLE) ? wdata : lat_wdata;
        wr  = (state == IDLE) ? memwrite : lat_wr;
    end

    // state, request latch and registered outputs derived from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE) begin
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_wr    <= memwrite;
            end
            ready <= (nxt == RESP) || (nxt == ERR);
            err   <= (nxt == ERR);
            busy  <= (nxt != IDLE);
            if (nxt == ERR)
                rdata <= '0;
            else if (nxt == RESP && !wr)
                rdata <= mem[idx];
        end
    end

    // storage commits a store on the edge entering RESP; never while reset is held
    always_ff @(posedge clk) begin
        if (!rst && nxt == RESP && wr)
            mem[idx] <= wd;
    end
endmodule
